// File: rtl/serial_frame_checker_pkg.sv
// serial_pkg: frame FSM states and parity-sense encodings shared with the upstream parity stage
package serial_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam bit EVEN = 1'b0;
  localparam bit ODD = 1'b1;
endpackage

// File: rtl/serial_frame_checker_if.sv
// serial_frame_checker_if: serial input (x, bit_en) plus received word, valid pulse, error flags, busy and error count
interface serial_frame_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 8
);
  logic x;
  logic bit_en;
  logic [DATA_W-1:0] data;
  logic data_valid;
  logic parity_err;
  logic frame_err;
  logic busy;
  logic [CNT_W-1:0] err_count;
  modport master (output x, bit_en, input data, data_valid, parity_err, frame_err, busy, err_count);
  modport slave (input x, bit_en, output data, data_valid, parity_err, frame_err, busy, err_count);
endinterface

// File: rtl/serial_frame_checker_parity_acc.sv
// parity_acc: 1-bit running XOR of x over enabled cycles; ports clk, rst_n, clr, en, x in, p out
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic p
);
  always_ff @(posedge clk) p <= (!rst_n || clr) ? 1'b0 : p ^ (en & x);
endmodule

// File: rtl/serial_frame_checker.sv
// serial_frame_checker: start/data(LSB first)/parity/stop deserializer with error flags and saturating error count; ports clk, rst_n, bus (slave)
module serial_frame_checker
  import serial_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit ODD_PARITY = EVEN,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  serial_frame_checker_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sreg;
  logic par, mis, start, shift, last, done, err;
  assign start = state == IDLE && bus.bit_en && !bus.x;
  assign shift = state == DATA && bus.bit_en;
  assign last = cnt == CW'(DATA_W - 1);
  assign done = state == STOP && bus.bit_en;
  assign err = mis || !bus.x;
  assign bus.busy = state != IDLE;
  parity_acc u_par (.clk, .rst_n, .clr(start), .en(shift), .x(bus.x), .p(par));
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (bus.bit_en)
      case (state)
        IDLE: if (!bus.x) state_nx = DATA;
        DATA: if (last) state_nx = PARITY;
        PARITY: state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sreg <= '0;
      mis <= 1'b0;
      bus.data <= '0;
      bus.data_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.data_valid <= done;
      if (start) begin
        cnt <= '0;
        sreg <= '0;
      end
      if (shift) begin
        sreg <= (sreg >> 1) | (DATA_W'(bus.x) << (DATA_W - 1));
        cnt <= cnt + 1'b1;
      end
      if (state == PARITY && bus.bit_en) mis <= bus.x != (par ^ ODD_PARITY);
      if (done) begin
        bus.data <= sreg;
        bus.parity_err <= mis;
        bus.frame_err <= !bus.x;
        if (err && !(&bus.err_count)) bus.err_count <= bus.err_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_checker.sv
// tb_serial_frame_checker: randomized frames checked every cycle against a frame-level model, plus literal spot checks
module tb_serial_frame_checker;
  import serial_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serial_frame_checker_if #(.DATA_W(8), .CNT_W(8)) ia ();
  serial_frame_checker_if #(.DATA_W(4), .CNT_W(2)) ib ();
  serial_frame_checker #(.DATA_W(8), .ODD_PARITY(EVEN), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  serial_frame_checker #(.DATA_W(4), .ODD_PARITY(ODD), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  int dw[2] = '{8, 4};
  int cmax[2] = '{255, 3};
  bit odd[2] = '{1'b0, 1'b1};
  int m_data[2];
  int m_cnt[2];
  bit m_valid[2];
  bit m_pe[2];
  bit m_fe[2];
  bit m_busy[2];
  int n_chk = 0;
  int n_fail = 0;
  bit on = 1'b0;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_data[s] = 0;
      m_cnt[s] = 0;
      m_valid[s] = 1'b0;
      m_pe[s] = 1'b0;
      m_fe[s] = 1'b0;
      m_busy[s] = 1'b0;
    end
  endfunction
  always @(negedge clk) if (on) begin
    check("a_valid", ia.data_valid, m_valid[0]);
    check("a_data", ia.data, m_data[0]);
    check("a_parity_err", ia.parity_err, m_pe[0]);
    check("a_frame_err", ia.frame_err, m_fe[0]);
    check("a_busy", ia.busy, m_busy[0]);
    check("a_err_count", ia.err_count, m_cnt[0]);
    check("b_valid", ib.data_valid, m_valid[1]);
    check("b_data", ib.data, m_data[1]);
    check("b_parity_err", ib.parity_err, m_pe[1]);
    check("b_frame_err", ib.frame_err, m_fe[1]);
    check("b_busy", ib.busy, m_busy[1]);
    check("b_err_count", ib.err_count, m_cnt[1]);
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
  end
  task automatic drive(int s, bit b, bit en);
    if (s == 0) begin
      ia.x = b;
      ia.bit_en = en;
    end else begin
      ib.x = b;
      ib.bit_en = en;
    end
    @(posedge clk);
    #1;
    ia.bit_en = 1'b0;
    ib.bit_en = 1'b0;
  endtask
  task automatic put_bit(int s, bit b, int gaps);
    int n = gaps < 0 ? int'($urandom_range(0, 2)) : gaps;
    repeat (n) drive(s, 1'($urandom_range(0, 1)), 1'b0);
    drive(s, b, 1'b1);
  endtask
  task automatic send_frame(int s, int d, bit flip, bit stop, int gaps);
    bit p = odd[s] ^ flip;
    for (int i = 0; i < dw[s]; i++) p ^= d[i];
    put_bit(s, 1'b0, gaps);
    m_busy[s] = 1'b1;
    for (int i = 0; i < dw[s]; i++) put_bit(s, d[i], gaps);
    put_bit(s, p, gaps);
    put_bit(s, stop, gaps);
    m_data[s] = d & ((1 << dw[s]) - 1);
    m_pe[s] = flip;
    m_fe[s] = !stop;
    m_valid[s] = 1'b1;
    m_busy[s] = 1'b0;
    if (flip || !stop) m_cnt[s] = m_cnt[s] == cmax[s] ? cmax[s] : m_cnt[s] + 1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    ia.x = 1'b1;
    ia.bit_en = 1'b0;
    ib.x = 1'b1;
    ib.bit_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    on = 1'b1;
    check("rst_data", ia.data, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_count", ia.err_count, 0);
    repeat (3) drive(0, 1'b1, 1'b1);
    send_frame(0, 'hA5, 1'b0, 1'b1, 0);
    check("lit_a5_data", ia.data, 'hA5);
    check("lit_a5_valid", ia.data_valid, 1);
    check("lit_a5_pe", ia.parity_err, 0);
    check("lit_a5_cnt", ia.err_count, 0);
    send_frame(0, 'hA5, 1'b1, 1'b1, 0);
    check("lit_bad_par_pe", ia.parity_err, 1);
    check("lit_bad_par_data", ia.data, 'hA5);
    check("lit_bad_par_cnt", ia.err_count, 1);
    send_frame(0, 'h3C, 1'b0, 1'b0, 0);
    check("lit_3c_fe", ia.frame_err, 1);
    check("lit_3c_pe", ia.parity_err, 0);
    check("lit_3c_cnt", ia.err_count, 2);
    send_frame(0, 'h81, 1'b0, 1'b1, 1);
    check("lit_81_data", ia.data, 'h81);
    check("lit_81_fe", ia.frame_err, 0);
    put_bit(0, 1'b0, 0);
    m_busy[0] = 1'b1;
    for (int i = 0; i < 4; i++) put_bit(0, 1'b1, 0);
    do_reset();
    check("lit_midrst_busy", ia.busy, 0);
    check("lit_midrst_data", ia.data, 0);
    check("lit_midrst_cnt", ia.err_count, 0);
    send_frame(0, 'h0F, 1'b0, 1'b1, 0);
    check("lit_0f_data", ia.data, 'h0F);
    send_frame(0, 'h55, 1'b0, 1'b1, 0);
    send_frame(0, 'hAA, 1'b1, 1'b1, 0);
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) drive(0, 1'b1, 1'b1);
      send_frame(0, int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0 ? -1 : 0);
    end
    send_frame(1, 'h9, 1'b0, 1'b1, 0);
    check("lit_b_good_pe", ib.parity_err, 0);
    check("lit_b_good_data", ib.data, 'h9);
    for (int k = 0; k < 5; k++) begin
      send_frame(1, int'($urandom_range(0, 15)), 1'b1, 1'b1, 0);
      check("lit_b_sat", ib.err_count, k < 3 ? k + 1 : 3);
    end
    repeat (10)
      send_frame(1, int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0 ? -1 : 0);
    repeat (3) drive(0, 1'b1, 1'b0);
    on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_frame_checker.md
Name: serial_frame_checker

Overview:
Downstream consumer of the serial parity stream. It receives a bit-serial frame of one start bit, DATA_W data bits (LSB first), one parity bit and one stop bit. It reassembles the data word, checks the parity bit against a running even/odd state, and checks the stop bit. It presents the word with a one-cycle valid pulse, error flags, and a saturating error counter for system status.

Parameters:
- DATA_W, 8, number of data bits per frame (range 1..16).
- ODD_PARITY, 0, 0 = even parity (total ones over data+parity is even); 1 = odd parity.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- x  input  1  serial data bit, sampled only when bit_en=1.
- bit_en  input  1  bit strobe; one serial bit per cycle in which bit_en=1.
- data  output  DATA_W  last received data word; holds until next frame completes.
- data_valid  output  1  one-cycle pulse when a frame completes (good or bad).
- parity_err  output  1  parity mismatch on the completed frame; valid with data_valid, holds until next completion.
- frame_err  output  1  stop bit was 0 on the completed frame; valid with data_valid, holds until next completion.
- busy  output  1  high while in any state other than IDLE.
- err_count  output  CNT_W  saturating count of frames with parity_err or frame_err.

Behaviour:
- All state is updated on the rising edge of clk. Reset is synchronous: rst_n=0 at an edge returns the block to its reset values.
- Reset values: state=IDLE, data=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0, bit counter=0, running parity=0.
- Cycles with bit_en=0 hold all state. data_valid is forced to 0 in every cycle except the completion cycle.
- State machine (advances only on bit_en=1):
  - IDLE: x=0 (start bit) -> DATA, clear shift register, bit counter and running parity. x=1 -> stay in IDLE (line idle).
  - DATA: shift x into bit position [counter], LSB first; running parity ^= x; counter++. After DATA_W bits -> PARITY.
  - PARITY: expected parity bit = running parity XOR ODD_PARITY; mismatch latched internally -> STOP.
  - STOP: data <= shift register; parity_err <= latched mismatch; frame_err <= ~x; data_valid <= 1 for exactly one cycle -> IDLE.
- Latency: data, data_valid, parity_err and frame_err appear on the edge that samples the stop bit, i.e. visible the cycle after that bit_en cycle.
- err_count increments by 1 at completion if parity_err|frame_err. It saturates at all-ones with no wrap.
- A frame with a frame error still delivers data; no resynchronisation or hunting is performed. The next start bit is accepted only from IDLE.
- Back-to-back frames: bit_en may be high on the cycle right after the STOP bit. That bit is treated in IDLE as a possible start bit.
- Reset mid-frame: the partial frame is discarded, no data_valid is produced, and err_count clears.
- Width rules: bit counter is clog2(DATA_W+1) bits wide. The running parity is a single bit, equal to the XOR of the data bits received so far.

Decomposition:
- Shared package serial_pkg holds the state enum (IDLE, DATA, PARITY, STOP) and localparams EVEN=0 / ODD=1, so these encodings are shared with the upstream parity stage.
- One sub-module, parity_acc: a 1-bit running-parity accumulator with clear, enable and x inputs.
- Shift register, counter and FSM stay in the top.

Test Plan:
- Reset then 0xA5 even parity: start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, bit_en=1 each cycle -> data=0xA5, data_valid one cycle, parity_err=0, frame_err=0, err_count=0.
- Same frame with parity bit 1 -> parity_err=1, data=0xA5, err_count=1.
- 0x3C with stop bit 0 -> frame_err=1, parity_err=0, err_count increments.
- bit_en toggled 1/0 every other cycle while sending 0x81 -> identical result to the continuous case; data_valid lasts exactly one cycle; busy is high from the start bit to completion.
- rst_n=0 for one cycle after 4 data bits -> no data_valid; outputs at reset values. The next full frame 0x0F is received correctly.
- ODD_PARITY=1, DATA_W=4, CNT_W=2: send five frames with bad parity -> err_count reads 1, 2, 3, 3, 3 (saturation).
